// File: rtl/puf_response_collector.sv
// rtl/puf_response_collector.sv - majority-voting response collector for a toggle-arbiter PUF chain
module puf_response_collector #(
    parameter int N_EVAL     = 15,
    parameter int RESP_BITS  = 32,
    parameter int SETTLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 puf_t,
    input  logic                 puf_resp,
    output logic [RESP_BITS-1:0] resp_word,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [7:0]           unstable_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SETTLE,
        S_SAMPLE,
        S_VOTE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           settle_cnt_q, settle_cnt_d;
    logic [7:0]           eval_cnt_q, eval_cnt_d;
    logic [7:0]           ones_cnt_q, ones_cnt_d;
    logic [7:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           unstable_q, unstable_d;
    logic [RESP_BITS-1:0] resp_word_q, resp_word_d;
    logic                 puf_t_q, puf_t_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic                 vote_bit;

    // Next-state and next-output computation; every output is derived from the next state so it is registered.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        eval_cnt_d   = eval_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        unstable_d   = unstable_q;
        resp_word_d  = resp_word_q;
        valid_d      = valid_q;
        vote_bit     = (ones_cnt_q > 8'(N_EVAL / 2));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_LAUNCH;
                    resp_word_d  = '0;
                    unstable_d   = '0;
                    bit_cnt_d    = '0;
                    eval_cnt_d   = '0;
                    ones_cnt_d   = '0;
                    settle_cnt_d = '0;
                end
            end
            S_LAUNCH: begin
                state_d      = S_SETTLE;
                settle_cnt_d = '0;
            end
            S_SETTLE: begin
                if (settle_cnt_q == 8'(SETTLE_CYC - 1)) begin
                    state_d      = S_SAMPLE;
                    settle_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            S_SAMPLE: begin
                // The arbiter bit only ever reaches the counters here.
                ones_cnt_d = ones_cnt_q + {7'd0, puf_resp};
                eval_cnt_d = eval_cnt_q + 8'd1;
                state_d    = (eval_cnt_d == 8'(N_EVAL)) ? S_VOTE : S_LAUNCH;
            end
            S_VOTE: begin
                // Written as shift/or so a one-bit word needs no empty slice.
                resp_word_d = (resp_word_q >> 1) | (RESP_BITS'(vote_bit) << (RESP_BITS - 1));
                if ((ones_cnt_q != 8'd0) && (ones_cnt_q != 8'(N_EVAL))) begin
                    unstable_d = unstable_q + 8'd1;
                end
                ones_cnt_d = '0;
                eval_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + 8'd1;
                if (bit_cnt_d == 8'(RESP_BITS)) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                end else begin
                    state_d = S_LAUNCH;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d     = S_IDLE;
                    valid_d     = 1'b0;
                    resp_word_d = '0;
                    unstable_d  = '0;
                    bit_cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        puf_t_d = (state_d == S_LAUNCH);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any run so no partial word is ever shown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            settle_cnt_q <= '0;
            eval_cnt_q   <= '0;
            ones_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            unstable_q   <= '0;
            resp_word_q  <= '0;
            puf_t_q      <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            eval_cnt_q   <= eval_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            unstable_q   <= unstable_d;
            resp_word_q  <= resp_word_d;
            puf_t_q      <= puf_t_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
        end
    end

    assign puf_t        = puf_t_q;
    assign busy         = busy_q;
    assign resp_valid   = valid_q;
    assign resp_word    = resp_word_q;
    assign unstable_cnt = unstable_q;

endmodule

// File: tb/tb_puf_response_collector.sv
// tb/tb_puf_response_collector.sv - randomized model-checked bench for puf_response_collector
module tb_puf_response_collector;

    localparam int NE    = 15;
    localparam int RB    = 32;
    localparam int SC    = 4;
    localparam int CPB   = NE * (SC + 2) + 1;
    localparam int TOTAL = RB * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        puf_t;
    logic        puf_resp = 1'b0;
    logic [31:0] resp_word;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  unstable_cnt;

    logic        start_s;
    logic        busy_s;
    logic        puf_t_s;
    logic        puf_resp_s = 1'b0;
    logic [3:0]  resp_word_s;
    logic        resp_valid_s;
    logic        ready_s;
    logic [7:0]  unstable_s;

    puf_response_collector dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .puf_t(puf_t),
        .puf_resp(puf_resp), .resp_word(resp_word), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .unstable_cnt(unstable_cnt)
    );

    puf_response_collector #(.N_EVAL(3), .RESP_BITS(4), .SETTLE_CYC(1)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .busy(busy_s), .puf_t(puf_t_s),
        .puf_resp(puf_resp_s), .resp_word(resp_word_s), .resp_valid(resp_valid_s),
        .resp_ready(ready_s), .unstable_cnt(unstable_s)
    );

    always #5 clk = ~clk;

    int total_n = 0;
    int bad_n   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: per-evaluation sample table and the run position.
    logic [14:0] patt [RB];
    logic [31:0] exp_word;
    int          exp_unst;
    bit          run_on   = 1'b0;
    bit          check_en = 1'b0;
    int          p        = 0;
    int          launches = 0;
    int          since    = 100;
    int          cur      = 0;
    int          launches_s = 0;
    logic [31:0] got_word;
    logic [7:0]  got_unst;
    int          first_v;

    task automatic compute_expect();
        int ones;
        exp_word = '0;
        exp_unst = 0;
        for (int b = 0; b < RB; b++) begin
            ones = $countones(patt[b]);
            exp_word[b] = (ones > NE / 2);
            if (ones != 0 && ones != NE) exp_unst++;
        end
    endtask

    // Run position counter; a handshake ends the run in the model.
    always @(posedge clk) begin
        if (run_on) begin
            p = p + 1;
            if (p > TOTAL && resp_ready) run_on = 1'b0;
        end
    end

    // PUF stand-in: the tabled sample appears only on the cycle it is due, noise otherwise.
    always @(negedge clk) begin
        if (puf_t) begin
            cur = launches;
            launches++;
            since = 0;
        end else if (since < 1000) begin
            since++;
        end
        if (since == SC + 1 && cur < RB * NE) puf_resp = patt[cur / NE][cur % NE];
        else puf_resp = 1'($urandom_range(0, 1));
    end

    // Small-configuration PUF stand-in: samples 1,1,0 for every bit.
    always @(negedge clk) begin
        if (puf_t_s) begin
            puf_resp_s = ((launches_s % 3) != 2);
            launches_s++;
        end
    end

    // Cycle-by-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        bit e_valid;
        bit e_pt;
        if (check_en) begin
            e_valid = run_on && (p >= TOTAL);
            e_pt    = run_on && (p < TOTAL) && ((p % CPB) < NE * (SC + 2)) && (((p % CPB) % (SC + 2)) == 0);
            chk("busy", busy, run_on);
            chk("resp_valid", resp_valid, e_valid);
            chk("puf_t", puf_t, e_pt);
            if (e_valid) begin
                chk("resp_word", resp_word, exp_word);
                chk("unstable_cnt", unstable_cnt, exp_unst);
            end
        end
    end

    task automatic launch_run();
        compute_expect();
        @(negedge clk);
        launches = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        p = 0;
        run_on = 1'b1;
        start = 1'b0;
        first_v = -1;
    endtask

    task automatic finish_run(input bit early, input int hold);
        int guard;
        guard = 0;
        while (run_on && guard < TOTAL + 300) begin
            @(negedge clk);
            guard++;
            if (resp_valid && first_v < 0) first_v = p;
            if (run_on && p == TOTAL) begin
                got_word = resp_word;
                got_unst = unstable_cnt;
            end
            if (!run_on) begin
                start = 1'b0;
                resp_ready = 1'b0;
            end else begin
                start = 1'($urandom_range(0, 1));
                if (p >= TOTAL) resp_ready = (p >= TOTAL + hold);
                else resp_ready = early ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
        if (run_on) begin
            chk("run_timeout", 1, 0);
            run_on = 1'b0;
        end
        start = 1'b0;
        resp_ready = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int g;
        int n;
        reset = 1'b1;
        start = 1'b0;
        resp_ready = 1'b0;
        start_s = 1'b0;
        ready_s = 1'b0;
        got_word = '0;
        got_unst = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_puf_t", puf_t, 0);
        chk("rst_word", resp_word, 0);
        chk("rst_unst", unstable_cnt, 0);
        reset = 1'b0;
        @(negedge clk);
        check_en = 1'b1;

        // Stuck-one chain with 50 cycles of backpressure.
        for (int b = 0; b < RB; b++) patt[b] = '1;
        launch_run();
        finish_run(1'b0, 50);
        chk("stuck1_word", got_word, 32'hFFFF_FFFF);
        chk("stuck1_unst", got_unst, 0);
        chk("stuck1_valid_cycle", first_v, 2912);

        // Per-bit constant chain.
        n = 32'hA5C3_0F96;
        for (int b = 0; b < RB; b++) patt[b] = {15{n[b]}};
        launch_run();
        finish_run(1'b0, 0);
        chk("perbit_word", got_word, 32'hA5C3_0F96);
        chk("perbit_unst", got_unst, 0);

        // Noisy chain around the majority threshold.
        for (int b = 0; b < RB; b++) patt[b] = '0;
        patt[0] = 15'b101_0100_1011_0001;
        patt[1] = 15'b110_1001_1100_0011;
        launch_run();
        finish_run(1'b1, 0);
        chk("noisy_word", got_word, 32'h0000_0002);
        chk("noisy_unst", got_unst, 2);

        // Reset during the vote of bit 10, then a fresh full run.
        n = 32'hA5C3_0F96;
        for (int b = 0; b < RB; b++) patt[b] = {15{n[b]}};
        launch_run();
        g = 0;
        while (p < 10 * CPB + CPB - 1 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check_en = 1'b0;
        run_on = 1'b0;
        start = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", resp_valid, 0);
        chk("abort_puf_t", puf_t, 0);
        chk("abort_word", resp_word, 0);
        chk("abort_unst", unstable_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_en = 1'b1;
        launch_run();
        finish_run(1'b0, 3);
        chk("post_abort_word", got_word, 32'hA5C3_0F96);
        chk("post_abort_valid_cycle", first_v, 2912);

        // Random chains with random backpressure.
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < RB; b++) begin
                case ($urandom_range(0, 3))
                    0: patt[b] = '0;
                    1: patt[b] = '1;
                    default: patt[b] = 15'($urandom);
                endcase
            end
            launch_run();
            finish_run(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
        end

        // Small configuration: N_EVAL=3, SETTLE_CYC=1, RESP_BITS=4.
        check_en = 1'b0;
        @(negedge clk);
        launches_s = 0;
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        n = 0;
        while (!resp_valid_s && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("small_valid_cycle", n, 40);
        chk("small_word", resp_word_s, 4'hF);
        chk("small_unst", unstable_s, 4);
        chk("small_busy", busy_s, 1);
        @(negedge clk);
        ready_s = 1'b1;
        @(posedge clk);
        #1;
        ready_s = 1'b0;
        chk("small_valid_fall", resp_valid_s, 0);
        chk("small_idle", busy_s, 0);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule

// File: doc/puf_response_collector.md
Name: puf_response_collector

Overview:
- Downstream of the cascaded toggle-arbiter PUF chain.
- Drives the chain's toggle input, waits for the race to settle, then samples the registered arbiter bit.
- Repeats each evaluation N_EVAL times and majority-votes the samples into one stable response bit.
- Packs RESP_BITS voted bits into a response word, delivered on a valid/ready handshake with a count of non-unanimous bits.

Parameters:
- N_EVAL, 15, evaluations per response bit; must be odd, 1..255.
- RESP_BITS, 32, bits per response word; 1..255.
- SETTLE_CYC, 4, idle cycles after launch before sampling; 1..255.

Ports:
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- start  in  1  request one response word; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- puf_t  out  1  toggle/launch drive to PUF chain input T.
- puf_resp  in  1  registered arbiter output of the PUF chain.
- resp_word  out  RESP_BITS  assembled response word.
- resp_valid  out  1  resp_word is valid.
- resp_ready  in  1  consumer accepts resp_word.
- unstable_cnt  out  8  number of bits in resp_word whose N_EVAL samples were not unanimous.

Behaviour:
- Reset (async, active-high, clock clk):
  - state=IDLE; puf_t, busy, resp_valid = 0.
  - resp_word, unstable_cnt, and all internal counters = 0.
  - Reset mid-operation aborts immediately; no partial word is ever presented.
- States: IDLE, LAUNCH, SETTLE, SAMPLE, VOTE, DONE. All outputs are registered.
- IDLE: start=1 -> LAUNCH. On entry, clear resp_word, unstable_cnt, bit_cnt, eval_cnt and ones_cnt.
- LAUNCH: puf_t=1 for exactly this cycle -> SETTLE.
- SETTLE: puf_t=0 for exactly SETTLE_CYC cycles -> SAMPLE.
- SAMPLE: one cycle.
  - ones_cnt += puf_resp; eval_cnt += 1.
  - If eval_cnt reaches N_EVAL -> VOTE, else -> LAUNCH.
- VOTE: one cycle.
  - bit = (ones_cnt > N_EVAL/2, integer division).
  - Shift right: resp_word <= {bit, resp_word[RESP_BITS-1:1]}. The first voted bit ends in resp_word[0]; the last ends in the MSB.
  - If ones_cnt is neither 0 nor N_EVAL, increment unstable_cnt.
  - Clear ones_cnt and eval_cnt; bit_cnt += 1.
  - If bit_cnt reaches RESP_BITS -> DONE with resp_valid=1 at that edge; else -> LAUNCH.
- Timing:
  - Cycles per bit = N_EVAL*(SETTLE_CYC+2)+1; 91 with defaults.
  - resp_valid rises exactly RESP_BITS*(N_EVAL*(SETTLE_CYC+2)+1) cycles after the edge that accepted start; 2912 with defaults.
- DONE: resp_word and unstable_cnt are held stable while resp_valid=1.
  - resp_valid && resp_ready at an edge -> resp_valid=0 -> IDLE.
  - resp_ready may already be high when valid rises; the handshake then completes one cycle later.
- Ignored inputs:
  - start is ignored in every state except IDLE, including DONE and the handshake cycle. A new request needs start=1 while in IDLE.
  - resp_ready is ignored outside DONE.
- Boundary cases:
  - N_EVAL=1: vote equals the single sample; unstable_cnt always 0.
  - ones_cnt is sized to hold N_EVAL and never wraps.
  - unstable_cnt never exceeds RESP_BITS, so it cannot overflow.
  - puf_resp is sampled only in SAMPLE; glitches elsewhere have no effect.

Test Plan:
- Stuck-one model (puf_resp=1), defaults, start pulse -> 32 LAUNCH pulses per bit group x 15 evaluations; resp_valid at cycle 2912; resp_word=0xFFFFFFFF; unstable_cnt=0.
- Per-bit model returning bit i of 0xA5C3_0F96 on all evaluations of bit i -> resp_word=0xA5C30F96; unstable_cnt=0; each puf_t pulse exactly 1 cycle, spaced 6 cycles apart.
- Noisy model: bit 0 gives 7 ones of 15, bit 1 gives 8 ones of 15, others all-zero -> resp_word[0]=0, resp_word[1]=1, remaining bits 0; unstable_cnt=2.
- Backpressure: hold resp_ready=0 for 50 cycles after valid, toggling start -> resp_word/unstable_cnt stable, no new run; resp_ready=1 -> valid falls next edge; busy=0.
- Reset asserted in VOTE of bit 10 -> all outputs 0 immediately (async); new start gives a full fresh 2912-cycle run with correct word.
- N_EVAL=3, SETTLE_CYC=1, RESP_BITS=4, puf_resp pattern 1,1,0 per bit -> resp_word=4'hF; unstable_cnt=4; resp_valid at cycle 4*(3*3+1)=40.
